// File: rtl/r2sdf_pkg.sv
// Shared types and constant helpers for the R2SDF FFT sequencer.
package r2sdf_pkg;

  // Complex sample as carried by the bf_stage datapath.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cpx_t;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} seq_state_e;

  // Feedback delay of stage n (1-based) in an N-stage pipeline.
  function automatic int unsigned stage_delay(int unsigned n_log2, int unsigned n);
    return 1 << (n_log2 - n);
  endfunction

  // Advances before stage n sees its first sample: sum of upstream delays.
  function automatic int unsigned stage_lat(int unsigned n_log2, int unsigned n);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 1; i < n; i++) acc += stage_delay(n_log2, i);
    return acc;
  endfunction

  // Reverse the low w bits of v.
  function automatic logic [31:0] bitrev(logic [31:0] v, int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[w-1-i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/r2sdf_seq_ctrl_if.sv
// Source/stage-chain control bundle for the R2SDF sequencer.
// Optional R2SDF_OUT_IDX_EN adds the natural-order bin index out_idx.
interface r2sdf_seq_ctrl_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned TW_W = N - 1;

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              adv;
  logic              zero_in;
  logic [N-1:0]      stage_bf;
  logic [N*TW_W-1:0] stage_tw;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              busy;
`ifdef R2SDF_OUT_IDX_EN
  logic [N-1:0]      out_idx;
`endif

  // Sequencer side.
  modport master (
    input  in_valid, flush,
    output in_ready, adv, zero_in, stage_bf, stage_tw, out_valid, out_sop, out_eop, busy
`ifdef R2SDF_OUT_IDX_EN
    , output out_idx
`endif
  );

  // Source / datapath side.
  modport slave (
    output in_valid, flush,
    input  in_ready, adv, zero_in, stage_bf, stage_tw, out_valid, out_sop, out_eop, busy
`ifdef R2SDF_OUT_IDX_EN
    , input out_idx
`endif
  );

endinterface

// File: rtl/r2sdf_stage_seq.sv
// Per-stage decode: butterfly/bypass select and twiddle exponent from the global count.
module r2sdf_stage_seq
  import r2sdf_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned n = 1
) (
  input  logic [N-1:0] gcnt,
  input  logic         active,
  output logic         bf,
  output logic [N-2:0] tw
);
  localparam int unsigned TW_W = N - 1;
  localparam logic [N-1:0] Lat = N'(stage_lat(N, n));

  logic [N-1:0] lc;

  // Local count -> select bit; twiddle is lc[N-n-1:0] << (n-1), which truncation yields directly
  // (and which is always zero for the last stage).
  always_comb begin
    lc = gcnt - Lat;
    bf = active & lc[N-n];
    tw = '0;
    if (active && !lc[N-n]) tw = TW_W'(lc << (n - 1));
  end

endmodule

// File: rtl/r2sdf_seq_ctrl.sv
// Central sequencer for an N-stage R2SDF FFT: advance strobe, per-stage control, fill tracking,
// zero-fill drain and output framing. Optional R2SDF_OUT_IDX_EN adds registered out_idx.
module r2sdf_seq_ctrl
  import r2sdf_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input logic              clk,
  input logic              rst_n,
  r2sdf_seq_ctrl_if.master bus
);
  localparam int unsigned TW_W = N - 1;
  // gcnt of the last FILL advance, and slot of the last DRAIN advance (both Ltot-1).
  localparam logic [N:0]   LastFill  = (N + 1)'((1 << N) - 2);
  localparam logic [N-1:0] LastDrain = N'((1 << N) - 2);

  seq_state_e        state_q;
  logic [N:0]        gcnt_q;
  logic [N-1:0]      ocnt_q;
  logic              flush_pend_q;
  logic              out_valid_q, out_sop_q, out_eop_q;

  logic [N-1:0]      slot;
  logic              flush_now, in_ready, adv, producing;
  logic [N-1:0]      active, stage_bf;
  logic [N*TW_W-1:0] stage_tw;

  assign slot      = gcnt_q[N-1:0];
  // A pending or same-cycle flush takes the frame boundary and blocks the input sample.
  assign flush_now = (flush_pend_q | bus.flush) & (slot == '0)
                   & ((state_q == StFill) || (state_q == StRun));
  assign in_ready  = (state_q != StDrain) & ~flush_now;
  assign adv       = rst_n & ((bus.in_valid & in_ready) | (state_q == StDrain));
  assign producing = adv & ((state_q == StRun) || (state_q == StDrain));

  for (genvar i = 0; i < N; i++) begin : g_stage
    localparam logic [N:0] Lat = (N + 1)'(stage_lat(N, i + 1));
    // Counter wraps in RUN/DRAIN, so the state keeps upstream-filled stages active.
    assign active[i] = (state_q == StRun) || (state_q == StDrain) || (gcnt_q >= Lat);

    r2sdf_stage_seq #(
      .N (N),
      .n (i + 1)
    ) u_stage (
      .gcnt   (gcnt_q[N-1:0]),
      .active (active[i]),
      .bf     (stage_bf[i]),
      .tw     (stage_tw[i*TW_W +: TW_W])
    );
  end

  // FSM, advance counter, flush latch and registered output framing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gcnt_q       <= '0;
      ocnt_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
    end else begin
      if (bus.flush && ((state_q == StFill) || (state_q == StRun))) flush_pend_q <= 1'b1;
      if (adv) gcnt_q <= gcnt_q + 1'b1;
      out_valid_q <= producing;
      out_sop_q   <= producing & (ocnt_q == '0);
      out_eop_q   <= producing & (ocnt_q == '1);
      if (producing) ocnt_q <= ocnt_q + 1'b1;
      unique case (state_q)
        StIdle: if (adv) state_q <= StFill;
        StFill, StRun: begin
          if (flush_now) begin
            state_q      <= StDrain;
            flush_pend_q <= 1'b0;
          end else if (state_q == StFill && adv && gcnt_q == LastFill) begin
            state_q <= StRun;
          end
        end
        StDrain: begin
          if (adv && slot == LastDrain) begin
            state_q <= StIdle;
            gcnt_q  <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef R2SDF_OUT_IDX_EN
  logic [N-1:0] out_idx_q;

  // Natural-order bin index, aligned with out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) out_idx_q <= '0;
    else        out_idx_q <= producing ? N'(bitrev(32'(ocnt_q), N)) : '0;
  end

  assign bus.out_idx = out_idx_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.adv       = adv;
  assign bus.zero_in   = (state_q == StDrain);
  assign bus.stage_bf  = stage_bf;
  assign bus.stage_tw  = stage_tw;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
